// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: baud divisors for a 12 MHz clock
// and the receiver FSM state encoding.
package uart_rx_pkg;

    // clk cycles per bit at 12 MHz
    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B300    = 40000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_baudgen.sv
// baudgen_rx: bit-period counter for the receiver. Counts 0..BAUD-1 while
// clk_ena is high, held at 0 otherwise. tick_half marks mid-bit of the
// start bit, tick marks one full bit period.
module baudgen_rx #(
    parameter int BAUD = 104
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic tick_half,
    output logic tick
);

    localparam int CW = $clog2(BAUD);

    logic [CW-1:0] cnt;

    // Free-running modulo-BAUD counter, cleared whenever disabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (!clk_ena)
            cnt <= '0;
        else if (cnt == CW'(BAUD - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Ticks decode the count only; the counter itself sits at 0 when disabled
    // and BAUD >= 4 keeps both decode values away from 0.
    assign tick_half = (cnt == CW'(BAUD / 2 - 1));
    assign tick      = (cnt == CW'(BAUD - 1));

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver at a fixed baud divisor.
// Optional feature macro: UART_RX_FERR_EN (framing-error strobe on ferr,
// bad frames discarded). Without it the stop bit is not checked.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv
`ifdef UART_RX_FERR_EN
    ,
    output logic       ferr
`endif
);

    state_t     state, state_next;
    logic       rx_meta, rx_s;
    logic [1:0] warm;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       clk_ena;
    logic       tick_half, tick;
    logic       stop_err;

    baudgen_rx #(.BAUD(BAUD)) u_baud (
        .clk       (clk),
        .rstn      (rstn),
        .clk_ena   (clk_ena),
        .tick_half (tick_half),
        .tick      (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state; the baud counter is held clear in IDLE and on every
    // transition so each state starts counting from 0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (armed && !rx_s) state_next = START;
            START: if (tick_half)      state_next = rx_s ? IDLE : DATA;
            DATA:  if (tick && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (tick)           state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
        clk_ena = (state != IDLE) && (state_next == state);
    end

`ifdef UART_RX_FERR_EN
    assign stop_err = (state == STOP) && tick && !rx_s;
`else
    assign stop_err = 1'b0;
`endif

    // Synchroniser, arming, shift register and output strobes.
    // warm keeps the reset value of the synchroniser from counting as a
    // high line: a frame may start only after a real high has been seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            warm    <= 2'b00;
            armed   <= 1'b0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            data    <= 8'h00;
            rcv     <= 1'b0;
`ifdef UART_RX_FERR_EN
            ferr    <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            warm    <= {warm[0], 1'b1};
            rcv     <= 1'b0;
            if (stop_err)
                armed <= 1'b0;
            else if (rx_s && warm[1])
                armed <= 1'b1;
            if (state != DATA)
                bit_cnt <= 3'd0;
            else if (tick)
                bit_cnt <= bit_cnt + 3'd1;
            if (state == DATA && tick)
                shift <= {rx_s, shift[7:1]};
`ifdef UART_RX_FERR_EN
            ferr <= stop_err;
            if (state == STOP && tick && rx_s) begin
                data <= shift;
                rcv  <= 1'b1;
            end
`else
            if (state == STOP && tick) begin
                data <= shift;
                rcv  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at BAUD=104 with a bench-driven serial line.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BAUD = B115200;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       rcv;
`ifdef UART_RX_FERR_EN
    logic       ferr;
`else
    logic       ferr = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rcv_cnt = 0;
    int ferr_cnt = 0;
    int width_err = 0;
    int overlap_err = 0;
    int last_rcv_cyc = 0;
    logic prev_rcv = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] rcv_q[$];

    uart_rx #(.BAUD(BAUD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv)
`ifdef UART_RX_FERR_EN
        ,
        .ferr (ferr)
`endif
    );

    always #1 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        prev_rcv  <= rcv;
        prev_ferr <= ferr;
        if (rcv && ferr) overlap_err <= overlap_err + 1;
        if (rcv) begin
            if (prev_rcv) width_err <= width_err + 1;
            else begin
                rcv_cnt <= rcv_cnt + 1;
                rcv_q.push_back(data);
                last_rcv_cyc <= cyc;
            end
        end
        if (ferr) begin
            if (prev_ferr) width_err <= width_err + 1;
            else ferr_cnt <= ferr_cnt + 1;
        end
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++;
        if (rcv !== 1'b0 || ferr !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: rcv=%b ferr=%b want 0 0", rcv, ferr); end
        n_cmp++;
        if (dut.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
        rstn = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic test_single;
        int c0, n0, lat;
        n0 = rcv_cnt;
        c0 = cyc;
        rcv_q.delete();
        send_byte(8'h41, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rcv_cnt != n0 + 1) begin n_bad++; $display("FAIL single_count: got %0d strobes want 1", rcv_cnt - n0); end
        n_cmp++;
        if (data !== 8'h41) begin n_bad++; $display("FAIL single_data: got %h want 41", data); end
        lat = last_rcv_cyc - c0;
        n_cmp++;
        if (lat < 987 || lat > 995) begin n_bad++; $display("FAIL single_latency: got %0d want 991+/-4", lat); end
        n_cmp++;
        if (width_err != 0) begin n_bad++; $display("FAIL single_width: got %0d long strobes want 0", width_err); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = rcv_cnt;
        rcv_q.delete();
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rcv_cnt != n0 + 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", rcv_cnt - n0); end
        else begin
            n_cmp++;
            if (rcv_q[0] !== 8'h55) begin n_bad++; $display("FAIL b2b_first: got %h want 55", rcv_q[0]); end
            n_cmp++;
            if (rcv_q[1] !== 8'hAA) begin n_bad++; $display("FAIL b2b_second: got %h want AA", rcv_q[1]); end
        end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = rcv_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        n_cmp++;
        if (rcv_cnt != n0) begin n_bad++; $display("FAIL glitch_strobe: got %0d strobes want 0", rcv_cnt - n0); end
        n_cmp++;
        if (dut.state !== IDLE) begin n_bad++; $display("FAIL glitch_state: got %0d want IDLE", dut.state); end
        n_cmp++;
        if (data !== 8'hAA) begin n_bad++; $display("FAIL glitch_data: got %h want AA", data); end
    endtask

    task automatic test_stop_err;
        int n0, f0;
        n0 = rcv_cnt;
        f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        rx = 1'b1;
`ifdef UART_RX_FERR_EN
        n_cmp++;
        if (ferr_cnt != f0 + 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        n_cmp++;
        if (rcv_cnt != n0) begin n_bad++; $display("FAIL ferr_rcv: got %0d strobes want 0", rcv_cnt - n0); end
        n_cmp++;
        if (data !== 8'hAA) begin n_bad++; $display("FAIL ferr_data: got %h want AA", data); end
`else
        n_cmp++;
        if (rcv_cnt != n0 + 1) begin n_bad++; $display("FAIL nostop_count: got %0d want 1", rcv_cnt - n0); end
        n_cmp++;
        if (data !== 8'h3C) begin n_bad++; $display("FAIL nostop_data: got %h want 3C", data); end
        n_cmp++;
        if (ferr_cnt != f0) begin n_bad++; $display("FAIL nostop_ferr: got %0d want 0", ferr_cnt - f0); end
`endif
        n_cmp++;
        if (overlap_err != 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d want 0", overlap_err); end
        repeat (12 * BAUD) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int n0;
        logic [7:0] b;
        b = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rx = 1'b0;
        repeat (BAUD / 2) @(negedge clk);
        n0 = rcv_cnt;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        n_cmp++;
        if (data !== 8'h00) begin n_bad++; $display("FAIL midreset_data: got %h want 00", data); end
        // line held low after reset must not start a frame
        repeat (3 * BAUD) @(negedge clk);
        n_cmp++;
        if (dut.state !== IDLE) begin n_bad++; $display("FAIL midreset_held_low: got state %0d want IDLE", dut.state); end
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        n_cmp++;
        if (rcv_cnt != n0) begin n_bad++; $display("FAIL midreset_strobe: got %0d want 0", rcv_cnt - n0); end
        send_byte(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rcv_cnt != n0 + 1 || data !== 8'h7E) begin
            n_bad++; $display("FAIL midreset_next: got %0d strobes data %h want 1 strobe data 7E", rcv_cnt - n0, data);
        end
    endtask

    task automatic test_loopback;
        logic [7:0] chars[5];
        chars = '{8'h00, 8'hFF, 8'hA5, 8'h0F, 8'h48};
        rcv_q.delete();
        for (int i = 0; i < 5; i++) send_byte(chars[i], 1'b1);
        repeat (2 * BAUD) @(negedge clk);
        n_cmp++;
        if (rcv_q.size() != 5) begin n_bad++; $display("FAIL loop_count: got %0d want 5", rcv_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (rcv_q[i] !== chars[i]) begin n_bad++; $display("FAIL loop_byte%0d: got %h want %h", i, rcv_q[i], chars[i]); end
            end
        end
        n_cmp++;
        if (width_err != 0 || overlap_err != 0) begin
            n_bad++; $display("FAIL strobe_shape: width_err=%0d overlap_err=%0d want 0 0", width_err, overlap_err);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_stop_err;
        test_reset_midframe;
        test_loopback;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
